shift_right_seq: RTL and testbench

Multi-cycle right shifter executing `srl`/`sra` (and `srlv`/`srav`) in the multicycle datapath, complementing the combinational left shift used for branch-offset and word-to-byte address scaling. It accepts an operand, a 5-bit shift amount and a logical/arithmetic select, shifts iteratively under a start/busy/done handshake, and holds the result for the ALU-out register. It sits beside the ALU and is sequenced by the controller.

---
 rtl/shift_pkg.sv | 27 ++
 rtl/shift_right_step.sv | 31 +++
 rtl/shift_right_seq.sv | 112 +++++++++++
 tb/tb_shift_right_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the multi-cycle right shifter.
//   shr_state_t : FSM encoding (IDLE / SHIFT / DONE)
//   SHR_STEP    : bits shifted per SHIFT cycle (2 with SHIFT_RADIX4_EN, else 1)
//   SHR_STEP_W  : width of a per-cycle step amount (holds 0..SHR_STEP)
//   SHAMT_W     : shift amount width
// Optional build macro: SHIFT_RADIX4_EN
// -----------------------------------------------------------------------------
package shift_pkg;

  typedef enum logic [1:0] {
    SHR_IDLE  = 2'd0,
    SHR_SHIFT = 2'd1,
    SHR_DONE  = 2'd2
  } shr_state_t;

`ifdef SHIFT_RADIX4_EN
  localparam int SHR_STEP = 2;
`else
  localparam int SHR_STEP = 1;
`endif

  localparam int SHR_STEP_W = $clog2(SHR_STEP + 1);
  localparam int SHAMT_W    = 5;

endpackage

// File: rtl/shift_right_step.sv
// -----------------------------------------------------------------------------
// shift_right_step
// Combinational right shift by 0..SHR_STEP bits, vacated MSBs take fill.
// Ports:
//   din  [WIDTH-1:0]      in   value to shift
//   amt  [SHR_STEP_W-1:0] in   shift amount, 0..SHR_STEP
//   fill                  in   bit shifted in at the MSB end
//   dout [WIDTH-1:0]      out  shifted value
// -----------------------------------------------------------------------------
module shift_right_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]      din,
  input  logic [SHR_STEP_W-1:0] amt,
  input  logic                  fill,
  output logic [WIDTH-1:0]      dout
);

  // Unrolled chain of single-bit shifts, each enabled while below amt.
  always_comb begin
    dout = din;
    for (int i = 0; i < SHR_STEP; i++) begin
      if (i < int'(amt)) begin
        dout = {fill, dout[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/shift_right_seq.sv
// -----------------------------------------------------------------------------
// shift_right_seq
// Multi-cycle logical/arithmetic right shifter for srl/sra/srlv/srav.
// Handshake: start is accepted only when busy=0 (IDLE or DONE). A request
// while busy is dropped, not queued. done pulses for exactly one cycle, and
// result is valid from that cycle until the next accepted start.
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   request, sampled only while busy=0
//   arith      in   1 = sign fill, 0 = zero fill
//   a          in   operand [WIDTH-1:0]
//   shamt      in   shift amount [SHAMT_W-1:0]
//   busy       out  high while in SHIFT
//   done       out  one-cycle completion pulse
//   result     out  latched working register [WIDTH-1:0]
//   state_dbg  out  current FSM state (shr_state_t encoding)
// Optional build macro: SHIFT_RADIX4_EN (two bits per SHIFT cycle).
// -----------------------------------------------------------------------------
module shift_right_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               arith,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic [1:0]         state_dbg
);

  shr_state_t         state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               fill_q, fill_d;

  logic [SHR_STEP_W-1:0] step_amt;
  logic [WIDTH-1:0]      step_out;
  logic                  accept;

  // step = min(remaining, SHR_STEP); in radix-4 mode a lone final bit is
  // taken as a single-bit step.
  always_comb begin
    if (rem_q > SHAMT_W'(SHR_STEP)) begin
      step_amt = SHR_STEP_W'(SHR_STEP);
    end else begin
      step_amt = rem_q[SHR_STEP_W-1:0];
    end
  end

  shift_right_step #(.WIDTH(WIDTH)) u_step (
    .din  (work_q),
    .amt  (step_amt),
    .fill (fill_q),
    .dout (step_out)
  );

  assign accept = start && (state_q != SHR_SHIFT);

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    fill_d  = fill_q;

    case (state_q)
      SHR_SHIFT: begin
        work_d = step_out;
        rem_d  = rem_q - SHAMT_W'(step_amt);
        if (rem_d == '0) begin
          state_d = SHR_DONE;
        end
      end
      SHR_DONE: state_d = SHR_IDLE;
      default:  state_d = SHR_IDLE;
    endcase

    // Accept overrides the DONE->IDLE return so back-to-back ops need no gap.
    // The sign is captured once here; fill never re-samples a.
    if (accept) begin
      work_d  = a;
      rem_d   = shamt;
      fill_d  = arith & a[WIDTH-1];
      state_d = (shamt == '0) ? SHR_DONE : SHR_SHIFT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SHR_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
    end
  end

  assign busy      = (state_q == SHR_SHIFT);
  assign done      = (state_q == SHR_DONE);
  assign result    = work_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_right_seq
// Directed self-checking bench for shift_right_seq. Inputs change on the
// falling edge; outputs are observed on the falling edge. Cycle 0 is the
// cycle whose closing rising edge samples start.
// -----------------------------------------------------------------------------
module tb_shift_right_seq;

`ifdef SHIFT_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        arith;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  shift_right_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .arith     (arith),
    .a         (a),
    .shamt     (shamt),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int k_of(input int sh);
    return (sh + STEP - 1) / STEP;
  endfunction

  // ---------------- drivers ----------------
  // Called at a falling edge: presents a request, lets the rising edge take
  // it, then scrambles the live operands to prove the DUT latched them.
  task automatic issue(input logic [31:0] op, input logic [4:0] sh, input logic ar);
    start = 1'b1;
    a     = op;
    shamt = sh;
    arith = ar;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 32'hDEAD_BEEF;
    shamt = 5'd17;
    arith = ~ar;
  endtask

  // Follows an issued op until done (bounded). Checks busy in cycles 1..k,
  // done in cycle k+1 and the result. poke>0 pulses a stray start in that
  // cycle. Returns at the falling edge of the done cycle.
  task automatic wait_done(input string tag, input int sh, input logic [31:0] exp_res,
                           input int poke);
    int k;
    int done_at;
    int busy_bad;
    k        = k_of(sh);
    done_at  = -1;
    busy_bad = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy !== (n <= k)) busy_bad++;
      if (done === 1'b1) begin
        done_at = n;
        break;
      end
      if (n == poke) begin
        start = 1'b1;
        a     = 32'h0000_0001;
        shamt = 5'd1;
        arith = 1'b0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, 32'(done_at), 32'(k + 1));
    check({tag, "_busy_bad"}, 32'(busy_bad), 32'd0);
    check({tag, "_result"}, result, exp_res);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    arith   = 1'b0;
    a       = '0;
    shamt   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // srl 0x80000000 >> 4
    issue(32'h8000_0000, 5'd4, 1'b0);
    wait_done("srl4", 4, 32'h0800_0000, 0);
    @(negedge clk);
    check("srl4_done_pulse", 32'(done), 32'd0);
    check("srl4_held", result, 32'h0800_0000);

    // sra 0x80000000 >> 31 (worst-case latency)
    issue(32'h8000_0000, 5'd31, 1'b1);
    wait_done("sra31", 31, 32'hFFFF_FFFF, 0);
    @(negedge clk);

    // shamt = 0: busy never rises, done in cycle 1
    issue(32'h1234_5678, 5'd0, 1'b0);
    wait_done("sh0", 0, 32'h1234_5678, 0);
    @(negedge clk);

    // sra 0xF0000000 >> 3 (odd amount exercises single-bit tail in radix-4)
    issue(32'hF000_0000, 5'd3, 1'b1);
    wait_done("sra3", 3, 32'hFE00_0000, 0);
    @(negedge clk);

    // srl with a set MSB must zero-fill
    issue(32'hF000_0000, 5'd3, 1'b0);
    wait_done("srl3", 3, 32'h1E00_0000, 0);
    @(negedge clk);

    // stray start while busy is ignored, then back-to-back start in DONE
    issue(32'hFFFF_0000, 5'd8, 1'b0);
    wait_done("ign", 8, 32'h00FF_FF00, 2);
    issue(32'h0000_0010, 5'd4, 1'b0);
    wait_done("b2b", 4, 32'h0000_0001, 0);
    @(negedge clk);

    // reset in cycle 3 of a shamt=20 shift
    issue(32'hABCD_1234, 5'd20, 1'b1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_result", result, 32'd0);
    begin
      int seen_done;
      seen_done = 0;
      for (int i = 0; i < 25; i++) begin
        @(negedge clk);
        if (done === 1'b1) seen_done++;
        if (i == 2) reset_n = 1'b1;
      end
      check("rstmid_no_done", 32'(seen_done), 32'd0);
    end
    check("rstmid_idle", 32'(state_dbg), 32'd0);

    issue(32'h0000_0100, 5'd8, 1'b0);
    wait_done("post_rst", 8, 32'h0000_0001, 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
